// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter owning a shared DATA_W-bit D-register.
// Optional macro DFF_ARB_FIXED_PRIO_EN: fixed priority, req[0] highest.
module dff_reg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int OWN_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    input  logic                      clr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      busy,
    output logic [DATA_W-1:0]         Q,
    output logic                      q_valid,
    output logic [OWN_W-1:0]          owner
);

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   w_gnt_nxt;
    logic [OWN_W-1:0]     r_win;
    logic [OWN_W-1:0]     w_win_nxt;
    logic [OWN_W-1:0]     r_ptr;
    logic [OWN_W-1:0]     r_owner;
    logic [DATA_W-1:0]    r_q;
    logic                 r_qv;
    logic [OWN_W-1:0]     w_win;
    logic                 w_found;
    logic                 w_wr_done;
    logic [OWN_W-1:0]     w_ptr_nxt;

    assign w_wr_done = (r_state == S_WRITE);
    assign w_ptr_nxt = (r_win == OWN_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;

    assign gnt     = r_gnt;
    assign busy    = w_wr_done;
    assign Q       = r_q;
    assign q_valid = r_qv;
    assign owner   = r_owner;

    // Scan from ptr downward-in-priority so the closest set bit wins last
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_win   = OWN_W'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Next-state and grant: one IDLE evaluation, then exactly one WRITE cycle
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_win_nxt   = r_win;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_WRITE;
                    w_gnt_nxt   = NUM_REQ'(1) << w_win;
                    w_win_nxt   = w_win;
                end
            end
            S_WRITE: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // FSM, grant and latched winner registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_win   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_win   <= w_win_nxt;
        end
    end

    // Shared register: clr wins over a completing write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q  <= '0;
            r_qv <= 1'b0;
        end else if (clr) begin
            r_q  <= '0;
            r_qv <= 1'b0;
        end else if (w_wr_done) begin
            r_q  <= wdata[r_win*DATA_W +: DATA_W];
            r_qv <= 1'b1;
        end
    end

    // Owner and round-robin pointer advance on every completed write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= '0;
            r_ptr   <= '0;
        end else if (w_wr_done) begin
            r_owner <= r_win;
`ifdef DFF_ARB_FIXED_PRIO_EN
            r_ptr   <= '0;
`else
            r_ptr   <= w_ptr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Scoreboard bench for dff_reg_arbiter (NUM_REQ=4, DATA_W=8).
// Honours DFF_ARB_FIXED_PRIO_EN for the priority scenario.
module tb_dff_reg_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic        clr;
    logic [3:0]  gnt;
    logic        busy;
    logic [7:0]  Q;
    logic        q_valid;
    logic [1:0]  owner;

    typedef struct {
        logic [1:0] own;
        logic [7:0] q;
        logic       qv;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    dff_reg_arbiter #(
        .NUM_REQ(4),
        .DATA_W (8),
        .OWN_W  (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .wdata  (wdata),
        .clr    (clr),
        .gnt    (gnt),
        .busy   (busy),
        .Q      (Q),
        .q_valid(q_valid),
        .owner  (owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Waits (bounded) at negedges until a grant is visible
    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (gnt != 4'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0;
        clr   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req   = 4'b0;
        clr   = 1'b0;
        wdata = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        checks += 5;
        if (gnt !== 4'b0)    begin errors++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
        if (busy !== 1'b0)   begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (Q !== 8'h00)     begin errors++; $display("FAIL rst_Q got=%h exp=00", Q); end
        if (q_valid !== 1'b0) begin errors++; $display("FAIL rst_qv got=%b exp=0", q_valid); end
        if (owner !== 2'd0)  begin errors++; $display("FAIL rst_owner got=%0d exp=0", owner); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks += 3;
        if (gnt !== 4'b0)    begin errors++; $display("FAIL rst_hold_gnt got=%b exp=0000", gnt); end
        if (Q !== 8'h00)     begin errors++; $display("FAIL rst_hold_Q got=%h exp=00", Q); end
        if (q_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_qv got=%b exp=0", q_valid); end
    endtask

    task automatic test_single();
        bit   ok;
        exp_t e;
        req           = 4'b0100;
        wdata[23:16]  = 8'hA5;
        wait_gnt(ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL single_timeout no grant"); end
        if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
        if (busy !== 1'b1)   begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
        sb.push_back('{own: 2'd2, q: 8'hA5, qv: 1'b1});
        req = 4'b0;
        @(negedge clk);
        e = sb.pop_front();
        checks += 4;
        if (Q !== e.q)       begin errors++; $display("FAIL single_Q got=%h exp=%h", Q, e.q); end
        if (owner !== e.own) begin errors++; $display("FAIL single_owner got=%0d exp=%0d", owner, e.own); end
        if (q_valid !== e.qv) begin errors++; $display("FAIL single_qv got=%b exp=%b", q_valid, e.qv); end
        if (gnt !== 4'b0)    begin errors++; $display("FAIL single_gnt_off got=%b exp=0000", gnt); end
    endtask

    task automatic test_round_robin();
        bit   ok;
        exp_t e;
        int   last;
        do_reset();
        for (int i = 0; i < 4; i++) wdata[i*8 +: 8] = 8'h10 + 8'(i);
        req  = 4'b1111;
        last = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(ok);
            checks += 2;
            if (!ok) begin errors++; $display("FAIL rr_timeout k=%0d", k); end
            if (gnt !== (4'b1 << k)) begin
                errors++;
                $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, gnt, 4'b1 << k);
            end
            sb.push_back('{own: 2'(k), q: 8'h10 + 8'(k), qv: 1'b1});
            req[k] = 1'b0;
            @(negedge clk);
            e = sb.pop_front();
            checks += 3;
            if (Q !== e.q)       begin errors++; $display("FAIL rr_Q k=%0d got=%h exp=%h", k, Q, e.q); end
            if (owner !== e.own) begin errors++; $display("FAIL rr_owner k=%0d got=%0d exp=%0d", k, owner, e.own); end
            if (busy !== 1'b0)   begin errors++; $display("FAIL rr_busy k=%0d got=%b exp=0", k, busy); end
            if (k > 0) begin
                checks++;
                if (cyc - last !== 2) begin
                    errors++;
                    $display("FAIL rr_spacing k=%0d got=%0d exp=2", k, cyc - last);
                end
            end
            last = cyc;
        end
    endtask

    task automatic test_fairness();
        bit   ok;
        exp_t e;
        logic [1:0] order [3];
        order[0] = 2'd0;
        order[1] = 2'd1;
        order[2] = 2'd3;
        req = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            wait_gnt(ok);
            checks += 2;
            if (!ok) begin errors++; $display("FAIL fair_timeout k=%0d", k); end
            if (gnt !== (4'b1 << order[k])) begin
                errors++;
                $display("FAIL fair_gnt k=%0d got=%b exp=%b", k, gnt, 4'b1 << order[k]);
            end
            sb.push_back('{own: order[k], q: 8'h10 + 8'(order[k]), qv: 1'b1});
            req[order[k]] = 1'b0;
            if (k == 0) req[1] = 1'b1;
            @(negedge clk);
            e = sb.pop_front();
            checks += 2;
            if (Q !== e.q)       begin errors++; $display("FAIL fair_Q k=%0d got=%h exp=%h", k, Q, e.q); end
            if (owner !== e.own) begin errors++; $display("FAIL fair_owner k=%0d got=%0d exp=%0d", k, owner, e.own); end
        end
    endtask

    task automatic test_clr_collision();
        bit   ok;
        exp_t e;
        req          = 4'b0010;
        wdata[15:8]  = 8'h3C;
        wait_gnt(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL clr_timeout no grant"); end
        if (gnt !== 4'b0010) begin errors++; $display("FAIL clr_gnt got=%b exp=0010", gnt); end
        sb.push_back('{own: 2'd1, q: 8'h00, qv: 1'b0});
        clr = 1'b1;
        req = 4'b0;
        @(negedge clk);
        clr = 1'b0;
        e = sb.pop_front();
        checks += 5;
        if (Q !== e.q)        begin errors++; $display("FAIL clr_Q got=%h exp=%h", Q, e.q); end
        if (q_valid !== e.qv) begin errors++; $display("FAIL clr_qv got=%b exp=%b", q_valid, e.qv); end
        if (owner !== e.own)  begin errors++; $display("FAIL clr_owner got=%0d exp=%0d", owner, e.own); end
        if (busy !== 1'b0)    begin errors++; $display("FAIL clr_busy got=%b exp=0", busy); end
        if (gnt !== 4'b0)     begin errors++; $display("FAIL clr_gnt_off got=%b exp=0000", gnt); end
    endtask

    task automatic test_priority();
        bit   ok;
        exp_t e;
        logic [1:0] second;
`ifdef DFF_ARB_FIXED_PRIO_EN
        second = 2'd0;
`else
        second = 2'd1;
`endif
        do_reset();
        wdata[7:0]  = 8'hA0;
        wdata[15:8] = 8'hA1;
        req = 4'b0011;
        wait_gnt(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL prio_timeout first"); end
        if (gnt !== 4'b0001) begin errors++; $display("FAIL prio_gnt1 got=%b exp=0001", gnt); end
        sb.push_back('{own: 2'd0, q: 8'hA0, qv: 1'b1});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (Q !== e.q) begin errors++; $display("FAIL prio_Q1 got=%h exp=%h", Q, e.q); end
        wait_gnt(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL prio_timeout second"); end
        if (gnt !== (4'b1 << second)) begin
            errors++;
            $display("FAIL prio_gnt2 got=%b exp=%b", gnt, 4'b1 << second);
        end
        sb.push_back('{own: second, q: (second == 2'd0) ? 8'hA0 : 8'hA1, qv: 1'b1});
        req = 4'b0;
        @(negedge clk);
        e = sb.pop_front();
        checks += 2;
        if (Q !== e.q)       begin errors++; $display("FAIL prio_Q2 got=%h exp=%h", Q, e.q); end
        if (owner !== e.own) begin errors++; $display("FAIL prio_owner2 got=%0d exp=%0d", owner, e.own); end
    endtask

    task automatic test_async_reset_mid_write();
        bit ok;
        req          = 4'b0010;
        wdata[15:8]  = 8'h99;
        wait_gnt(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL arst_timeout no grant"); end
        if (gnt !== 4'b0010) begin errors++; $display("FAIL arst_gnt got=%b exp=0010", gnt); end
        #2 rst_n = 1'b0;
        #1;
        checks += 5;
        if (gnt !== 4'b0)     begin errors++; $display("FAIL arst_gnt_off got=%b exp=0000", gnt); end
        if (busy !== 1'b0)    begin errors++; $display("FAIL arst_busy got=%b exp=0", busy); end
        if (Q !== 8'h00)      begin errors++; $display("FAIL arst_Q got=%h exp=00", Q); end
        if (q_valid !== 1'b0) begin errors++; $display("FAIL arst_qv got=%b exp=0", q_valid); end
        if (owner !== 2'd0)   begin errors++; $display("FAIL arst_owner got=%0d exp=0", owner); end
        req = 4'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks += 2;
        if (Q !== 8'h00)      begin errors++; $display("FAIL arst_noWrite_Q got=%h exp=00", Q); end
        if (q_valid !== 1'b0) begin errors++; $display("FAIL arst_noWrite_qv got=%b exp=0", q_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_clr_collision();
        test_priority();
        test_async_reset_mid_write();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
